// File: rtl/key_event_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared types for the key event controller: event codes and
//            per-key state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Event codes carried on evt_type
  typedef enum logic [1:0] {
    EVT_SHORT    = 2'd0,
    EVT_LONG     = 2'd1,
    EVT_REPEAT   = 2'd2,
    EVT_LONG_REL = 2'd3
  } evt_type_t;

  // Per-key classification states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } key_state_t;

  // Width of the key index on the event port
  localparam int KEY_IDX_W = 3;

endpackage
`default_nettype wire

// File: rtl/key_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl_if
// Purpose  : Valid/ready event port between the key controller (master)
//            and the application consumer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface key_event_ctrl_if
  import key_pkg::*;
  ;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [KEY_IDX_W-1:0] evt_key;
  evt_type_t            evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/key_event_ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module   : key_chan
// Purpose  : One key: 2-flop synchronizer, tick-sampled history, debounced
//            level and press classifier (short / long / repeat / release).
// Revision : 1.0 - initial release
// ============================================================================
module key_chan
  import key_pkg::*;
#(
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      key_n,
  output logic      pressed,
  output logic      evt_pulse,
  output evt_type_t evt_type
);

  localparam logic [7:0] C_LONG   = 8'(LONG_TICKS);
  localparam logic [7:0] C_REPEAT = 8'(REPEAT_TICKS);

  logic [1:0] r_sync;
  logic [3:0] r_hist;
  logic [3:0] w_hist_next;
  logic       r_tick_d;
  key_state_t r_state;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_inc;
  logic       w_unused_hist;

  assign w_hist_next   = {r_hist[2:0], ~r_sync[1]};
  assign w_hold_inc    = r_hold_cnt + 8'd1;
  assign w_unused_hist = r_hist[3];

  // Two-flop synchronizer; reset to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], key_n};
  end

  // Tick-sampled history; the level only moves on two equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist   <= 4'd0;
      pressed  <= 1'b0;
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= tick;
      if (tick) begin
        r_hist <= w_hist_next;
        if (w_hist_next[1:0] == 2'b11)      pressed <= 1'b1;
        else if (w_hist_next[1:0] == 2'b00) pressed <= 1'b0;
      end
    end
  end

  // Classifier, run the cycle after each tick so it sees the new level.
  // IDLE is only re-entered on release, so a high level there is a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 8'd0;
      evt_pulse  <= 1'b0;
      evt_type   <= EVT_SHORT;
    end else begin
      evt_pulse <= 1'b0;
      if (r_tick_d) begin
        case (r_state)
          ST_IDLE: begin
            if (pressed) begin
              r_state    <= ST_DOWN;
              r_hold_cnt <= 8'd0;
            end
          end
          ST_DOWN: begin
            if (!pressed) begin
              evt_pulse <= 1'b1;
              evt_type  <= EVT_SHORT;
              r_state   <= ST_IDLE;
            end else if (w_hold_inc == C_LONG) begin
              evt_pulse  <= 1'b1;
              evt_type   <= EVT_LONG;
              r_state    <= ST_HELD;
              r_hold_cnt <= 8'd0;
            end else begin
              r_hold_cnt <= w_hold_inc;
            end
          end
          ST_HELD: begin
            if (!pressed) begin
              evt_pulse <= 1'b1;
              evt_type  <= EVT_LONG_REL;
              r_state   <= ST_IDLE;
            end else if (C_REPEAT != 8'd0) begin
              if (w_hold_inc == C_REPEAT) begin
                evt_pulse  <= 1'b1;
                evt_type   <= EVT_REPEAT;
                r_hold_cnt <= 8'd0;
              end else begin
                r_hold_cnt <= w_hold_inc;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Purpose  : Multi-key front end: shared sample tick, per-key classifiers,
//            one pending slot per key, round-robin event output with
//            valid/ready and a sticky drop flag.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int TICK_CNT_W   = 20,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  key_event_ctrl_if.master    evt_if,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic                ovf,
  input  logic                ovf_clr
);

  logic [TICK_CNT_W-1:0] r_tick_cnt;
  logic                  w_tick;
  logic [NUM_KEYS-1:0]   w_evt_pulse;
  evt_type_t             w_evt_type [NUM_KEYS];
  logic [NUM_KEYS-1:0]   r_pending;
  evt_type_t             r_pend_type [NUM_KEYS];
  logic [2:0]            r_rr_ptr;
  logic [7:0]            w_pend_ext;
  logic                  w_load;
  logic                  w_grant_any;
  logic [2:0]            w_grant_idx;
  logic [NUM_KEYS-1:0]   w_grant;
  logic [NUM_KEYS-1:0]   w_drop;

  assign w_tick     = &r_tick_cnt;
  assign w_pend_ext = 8'(r_pending);
  assign w_load     = !evt_if.evt_valid || evt_if.evt_ready;

  // Free-running sample tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else        r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
  end

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
      key_chan #(
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (w_tick),
        .key_n     (key_n[k]),
        .pressed   (key_pressed[k]),
        .evt_pulse (w_evt_pulse[k]),
        .evt_type  (w_evt_type[k])
      );
    end
  endgenerate

  // Round-robin pick: first pending key at or after the pointer, wrapping
  always_comb begin
    logic [3:0] w_sum;
    logic [2:0] w_idx;
    w_sum       = 4'd0;
    w_idx       = 3'd0;
    w_grant_any = 1'b0;
    w_grant_idx = 3'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(i);
      if (w_sum >= 4'(NUM_KEYS)) w_sum = w_sum - 4'(NUM_KEYS);
      w_idx = w_sum[2:0];
      if (!w_grant_any && w_pend_ext[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_grant[k] = w_load && w_grant_any && (w_grant_idx == 3'(k));
      w_drop[k]  = w_evt_pulse[k] && r_pending[k] && !w_grant[k];
    end
  end

  // Pending slots and sticky overflow; a slot freed by this cycle's grant
  // can take a new event at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      ovf       <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) r_pend_type[k] <= EVT_SHORT;
    end else begin
      if (|w_drop)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_evt_pulse[k]) begin
          if (!w_drop[k]) begin
            r_pending[k]   <= 1'b1;
            r_pend_type[k] <= w_evt_type[k];
          end
        end else if (w_grant[k]) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads whenever it is empty or being accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_if.evt_valid <= 1'b0;
      evt_if.evt_key   <= '0;
      evt_if.evt_type  <= EVT_SHORT;
      r_rr_ptr         <= 3'd0;
    end else if (w_load) begin
      evt_if.evt_valid <= w_grant_any;
      if (w_grant_any) begin
        evt_if.evt_key <= w_grant_idx;
        r_rr_ptr       <= (w_grant_idx == 3'(NUM_KEYS - 1)) ? 3'd0 : w_grant_idx + 3'd1;
        for (int k = 0; k < NUM_KEYS; k++)
          if (w_grant[k]) evt_if.evt_type <= r_pend_type[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_event_ctrl
// Purpose  : Self-checking bench for key_event_ctrl: directed scenarios plus
//            randomized presses scored against a press-duration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;
  import key_pkg::*;

  localparam int NK = 4;
  localparam int TW = 4;
  localparam int LT = 5;
  localparam int RT = 2;
  localparam int TP = 16;   // clk cycles per tick

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_pressed;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  key_event_ctrl_if evt_if ();

  int checks = 0;
  int failures = 0;
  int exp_q [NK][$];
  int log_key [$];
  int log_cyc [$];
  int cyc = 0;
  bit rand_ready = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [2:0] prev_key = '0;
  logic [1:0] prev_type = '0;

  always #5 clk = ~clk;

  key_event_ctrl #(
    .NUM_KEYS     (NK),
    .TICK_CNT_W   (TW),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .evt_if      (evt_if),
    .key_pressed (key_pressed),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected events for one isolated press whose raw low level spans n ticks.
  // The debounced level lasts n ticks; LONG comes after LT ticks beyond the
  // first, then one REPEAT per further RT ticks, then the release event.
  task automatic expect_press(input int k, input int n);
    if (n < 2) return;
    if (n <= LT) begin
      exp_q[k].push_back(int'(EVT_SHORT));
    end else begin
      exp_q[k].push_back(int'(EVT_LONG));
      if (RT != 0)
        for (int r = 0; r < (n - LT - 1) / RT; r++) exp_q[k].push_back(int'(EVT_REPEAT));
      exp_q[k].push_back(int'(EVT_LONG_REL));
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) evt_if.evt_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic ticks(input int n);
    step(TP * n);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, evt_if.evt_valid, 0);
    check({tag, "_key"}, evt_if.evt_key, 0);
    check({tag, "_type"}, evt_if.evt_type, 0);
    check({tag, "_pressed"}, key_pressed, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  // Event monitor: handshake stability and per-key scoreboard
  always @(negedge clk) begin : mon
    int k;
    int et;
    cyc++;
    if (rst_n) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", evt_if.evt_valid, 1);
        check("hold_key", evt_if.evt_key, prev_key);
        check("hold_type", evt_if.evt_type, prev_type);
      end
      if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
        k = int'(evt_if.evt_key);
        log_key.push_back(k);
        log_cyc.push_back(cyc);
        check("evt_expected", (k < NK) && (exp_q[k].size() > 0), 1);
        if (k < NK && exp_q[k].size() > 0) begin
          et = exp_q[k].pop_front();
          check("evt_type", evt_if.evt_type, et);
        end
      end
    end
    prev_valid = rst_n && evt_if.evt_valid;
    prev_ready = evt_if.evt_ready;
    prev_key   = evt_if.evt_key;
    prev_type  = evt_if.evt_type;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n [NK];
    int mx;
    evt_if.evt_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    release_reset();

    // Reset mid-press: key1 qualifies, reset hits, then it must re-qualify
    key_n[1] = 1'b0;
    ticks(2);
    check("pre_rst_pressed1", key_pressed[1], 1);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    release_reset();
    ticks(1);
    check("requal_t1", key_pressed[1], 0);
    ticks(1);
    check("requal_t2", key_pressed[1], 1);

    // Short press: key1 held 3 ticks from reset release
    expect_press(1, 3);
    ticks(1);
    key_n[1] = 1'b1;
    check("short_still_pressed", key_pressed[1], 1);
    ticks(4);
    check("short_released", key_pressed[1], 0);
    check("short_drained", exp_q[1].size(), 0);

    // Single-tick glitch on key0
    key_n[0] = 1'b0;
    ticks(1);
    key_n[0] = 1'b1;
    ticks(3);
    check("glitch_pressed0", key_pressed[0], 0);
    check("glitch_valid", evt_if.evt_valid, 0);

    // Long press with repeats on key2
    log_key.delete(); log_cyc.delete();
    expect_press(2, 10);
    key_n[2] = 1'b0;
    ticks(10);
    key_n[2] = 1'b1;
    ticks(4);
    check("long_count", log_key.size(), 4);
    check("long_drained", exp_q[2].size(), 0);

    // Arbitration: key3 alone leaves the pointer at 0
    expect_press(3, 2);
    key_n[3] = 1'b0; ticks(2); key_n[3] = 1'b1; ticks(4);
    log_key.delete(); log_cyc.delete();
    expect_press(0, 2); expect_press(3, 2);
    key_n[0] = 1'b0; key_n[3] = 1'b0; ticks(2);
    key_n[0] = 1'b1; key_n[3] = 1'b1; ticks(4);
    check("arb0_n", log_key.size(), 2);
    if (log_key.size() == 2) begin
      check("arb0_first", log_key[0], 0);
      check("arb0_second", log_key[1], 3);
      check("arb0_b2b", log_cyc[1] - log_cyc[0], 1);
    end
    // key0 alone leaves the pointer at 1
    expect_press(0, 2);
    key_n[0] = 1'b0; ticks(2); key_n[0] = 1'b1; ticks(4);
    log_key.delete(); log_cyc.delete();
    expect_press(0, 2); expect_press(3, 2);
    key_n[0] = 1'b0; key_n[3] = 1'b0; ticks(2);
    key_n[0] = 1'b1; key_n[3] = 1'b1; ticks(4);
    check("arb1_n", log_key.size(), 2);
    if (log_key.size() == 2) begin
      check("arb1_first", log_key[0], 3);
      check("arb1_second", log_key[1], 0);
    end

    // Backpressure: the output register holds one key0 event, the pending
    // slot a second, so the third key0 event is the one dropped
    evt_if.evt_ready = 1'b0;
    exp_q[0].push_back(int'(EVT_SHORT));
    exp_q[0].push_back(int'(EVT_SHORT));
    exp_q[1].push_back(int'(EVT_SHORT));
    key_n[0] = 1'b0; ticks(2); key_n[0] = 1'b1; ticks(3);
    key_n[0] = 1'b0; key_n[1] = 1'b0; ticks(2);
    key_n[0] = 1'b1; key_n[1] = 1'b1; ticks(3);
    key_n[0] = 1'b0; ticks(2); key_n[0] = 1'b1; ticks(3);
    check("bp_valid", evt_if.evt_valid, 1);
    check("bp_key", evt_if.evt_key, 0);
    check("bp_ovf", ovf, 1);
    log_key.delete(); log_cyc.delete();
    evt_if.evt_ready = 1'b1;
    step(4);
    check("bp_n", log_key.size(), 3);
    if (log_key.size() == 3) begin
      check("bp_first", log_key[0], 0);
      check("bp_second", log_key[1], 1);
      check("bp_third", log_key[2], 0);
    end
    check("bp_empty_valid", evt_if.evt_valid, 0);
    check("bp_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Randomized rounds of overlapping presses with random backpressure
    rand_ready = 1;
    for (int r = 0; r < 12; r++) begin
      mx = 0;
      for (int k = 0; k < NK; k++) begin
        n[k] = $urandom_range(0, 11);
        expect_press(k, n[k]);
        if (n[k] > 0) key_n[k] = 1'b0;
        if (n[k] > mx) mx = n[k];
      end
      for (int t = 1; t <= mx; t++) begin
        ticks(1);
        for (int k = 0; k < NK; k++) if (n[k] == t) key_n[k] = 1'b1;
      end
      ticks(4);
    end
    rand_ready = 0;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      step(1);
    end
    for (int k = 0; k < NK; k++) check($sformatf("rand_drained%0d", k), exp_q[k].size(), 0);
    check("rand_ovf", ovf, 0);
    check("rand_idle_pressed", key_pressed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
